// File: rtl/display_bcd_sched.sv
// Round-robin display scheduler: grants one of two binary requesters, converts the
// captured value to BCD by shift-add-3, and commits four digits to the seven-segment outputs.
module display_bcd_sched #(
  parameter int WIDTH    = 12,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] val_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] val_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             busy,
  output logic             done,
  output logic             src,
  output logic [15:0]      bcd,
  output logic [6:0]       HEX_0,
  output logic [6:0]       HEX_1,
  output logic [6:0]       HEX_2,
  output logic [6:0]       HEX_3
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [15:0]      work_q, work_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             pending_src_q, pending_src_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             done_q, done_d;
  logic             src_q, src_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             grant_b;
  logic [15:0]      adj;
  logic [6:0]       hex_seg [4];

  // Add-3 correction applied to every work nibble before each shift.
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ? work_q[4*gi +: 4] + 4'd3
                                                        : work_q[4*gi +: 4];
  end

  always_comb begin
    state_d       = state_q;
    bin_d         = bin_q;
    work_d        = work_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    pending_src_d = pending_src_q;
    ack_a_d       = 1'b0;
    ack_b_d       = 1'b0;
    done_d        = 1'b0;
    src_d         = src_q;
    bcd_d         = bcd_q;
    grant_b       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          // On a tie the requester that did not win last time goes first.
          grant_b       = (req_a && req_b) ? ~last_grant_q : req_b;
          bin_d         = grant_b ? val_b : val_a;
          work_d        = '0;
          cnt_d         = '0;
          ack_a_d       = ~grant_b;
          ack_b_d       = grant_b;
          last_grant_d  = grant_b;
          pending_src_d = grant_b;
          state_d       = SHIFT;
        end
      end
      SHIFT: begin
        work_d = {adj[14:0], bin_q[WIDTH-1]};
        bin_d  = bin_q << 1;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = COMMIT;
      end
      COMMIT: begin
        bcd_d   = work_q;
        src_d   = pending_src_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bin_q         <= '0;
      work_q        <= '0;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      pending_src_q <= 1'b0;
      ack_a_q       <= 1'b0;
      ack_b_q       <= 1'b0;
      done_q        <= 1'b0;
      src_q         <= 1'b0;
      bcd_q         <= '0;
    end else begin
      state_q       <= state_d;
      bin_q         <= bin_d;
      work_q        <= work_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      pending_src_q <= pending_src_d;
      ack_a_q       <= ack_a_d;
      ack_b_q       <= ack_b_d;
      done_q        <= done_d;
      src_q         <= src_d;
      bcd_q         <= bcd_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h18;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Digits decode straight from the committed register, so they never show work state.
  for (genvar gi = 0; gi < 4; gi++) begin : g_hex
    if (gi == 0) begin : g_units
      assign hex_seg[gi] = seg7(bcd_q[3:0]);
    end else begin : g_upper
      assign hex_seg[gi] = (BLANK_LZ && (bcd_q[15:4*gi] == '0)) ? 7'h7F
                                                                 : seg7(bcd_q[4*gi +: 4]);
    end
  end

  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign src   = src_q;
  assign bcd   = bcd_q;
  assign HEX_0 = hex_seg[0];
  assign HEX_1 = hex_seg[1];
  assign HEX_2 = hex_seg[2];
  assign HEX_3 = hex_seg[3];

endmodule

// File: tb/tb_display_bcd_sched.sv
// Bench for display_bcd_sched: a transaction-level model predicts every output each cycle
// for a plain and a leading-zero-blanking instance; directed cases pin literal values.
module tb_display_bcd_sched;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0;
  logic [W-1:0] val_a = '0, val_b = '0;

  logic d0_ack_a, d0_ack_b, d0_busy, d0_done, d0_src;
  logic [15:0] d0_bcd;
  logic [6:0] d0_h0, d0_h1, d0_h2, d0_h3;
  logic d1_ack_a, d1_ack_b, d1_busy, d1_done, d1_src;
  logic [15:0] d1_bcd;
  logic [6:0] d1_h0, d1_h1, d1_h2, d1_h3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_bcd_sched #(.WIDTH(W), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .val_a(val_a), .req_b(req_b), .val_b(val_b),
    .ack_a(d0_ack_a), .ack_b(d0_ack_b), .busy(d0_busy), .done(d0_done), .src(d0_src),
    .bcd(d0_bcd), .HEX_0(d0_h0), .HEX_1(d0_h1), .HEX_2(d0_h2), .HEX_3(d0_h3));

  display_bcd_sched #(.WIDTH(W), .BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .val_a(val_a), .req_b(req_b), .val_b(val_b),
    .ack_a(d1_ack_a), .ack_b(d1_ack_b), .busy(d1_busy), .done(d1_done), .src(d1_src),
    .bcd(d1_bcd), .HEX_0(d1_h0), .HEX_1(d1_h1), .HEX_2(d1_h2), .HEX_3(d1_h3));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          model_valid = 1'b0;
  int          m_left = 0;          // cycles until commit; 0 means idle
  bit          m_last = 1'b1;       // 1 = B won last
  bit          m_pend_src = 1'b0;
  int          m_pend_val = 0;
  logic        exp_ack_a = 1'b0, exp_ack_b = 1'b0, exp_done = 1'b0, exp_src = 1'b0;
  logic [15:0] exp_bcd = '0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int n);
    case (n)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h18;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_hex(input logic [15:0] b, input int d, input bit blank);
    int v;
    v = int'(b);
    if (blank && d > 0 && (v >> (4 * d)) == 0) return 7'h7F;
    return seg_of((v >> (4 * d)) & 15);
  endfunction

  always @(posedge clk) begin
    model_valid = model_valid | !rst_n;
    if (!rst_n) begin
      m_left = 0; m_last = 1'b1; m_pend_src = 1'b0;
      exp_ack_a = 1'b0; exp_ack_b = 1'b0; exp_done = 1'b0; exp_src = 1'b0; exp_bcd = '0;
    end else begin
      exp_ack_a = 1'b0; exp_ack_b = 1'b0; exp_done = 1'b0;
      if (m_left == 0) begin
        if (req_a || req_b) begin
          m_pend_src = (req_a && req_b) ? !m_last : req_b;
          m_pend_val = m_pend_src ? int'(val_b) : int'(val_a);
          m_last = m_pend_src;
          exp_ack_a = !m_pend_src;
          exp_ack_b = m_pend_src;
          m_left = W + 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          exp_bcd = to_bcd(m_pend_val);
          exp_src = m_pend_src;
          exp_done = 1'b1;
          $display("commit src=%0d value=%0d bcd=%h", m_pend_src, m_pend_val, exp_bcd);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("ack_a", 16'(d0_ack_a), 16'(exp_ack_a));
      check("ack_b", 16'(d0_ack_b), 16'(exp_ack_b));
      check("busy", 16'(d0_busy), 16'(m_left != 0));
      check("done", 16'(d0_done), 16'(exp_done));
      check("src", 16'(d0_src), 16'(exp_src));
      check("bcd", d0_bcd, exp_bcd);
      check("hex0", 16'(d0_h0), 16'(exp_hex(exp_bcd, 0, 1'b0)));
      check("hex1", 16'(d0_h1), 16'(exp_hex(exp_bcd, 1, 1'b0)));
      check("hex2", 16'(d0_h2), 16'(exp_hex(exp_bcd, 2, 1'b0)));
      check("hex3", 16'(d0_h3), 16'(exp_hex(exp_bcd, 3, 1'b0)));
      check("lz_done", 16'(d1_done), 16'(exp_done));
      check("lz_bcd", d1_bcd, exp_bcd);
      check("lz_hex0", 16'(d1_h0), 16'(exp_hex(exp_bcd, 0, 1'b1)));
      check("lz_hex1", 16'(d1_h1), 16'(exp_hex(exp_bcd, 1, 1'b1)));
      check("lz_hex2", 16'(d1_h2), 16'(exp_hex(exp_bcd, 2, 1'b1)));
      check("lz_hex3", 16'(d1_h3), 16'(exp_hex(exp_bcd, 3, 1'b1)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ack(output bit who);
    who = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (d0_ack_a || d0_ack_b) begin
        who = d0_ack_b;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL ack_timeout: got none expected ack within 60 cycles");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (d0_done) return;
    end
    checks++; errors++;
    $display("FAIL done_timeout: got none expected done within 60 cycles");
  endtask

  task automatic convert(input bit use_b, input int v);
    bit who;
    if (use_b) begin val_b = W'(v); req_b = 1'b1; end
    else begin val_a = W'(v); req_a = 1'b1; end
    wait_ack(who);
    req_a = 1'b0; req_b = 1'b0;
    wait_done();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit who;
    int n;
    repeat (3) @(negedge clk);
    check("rst_bcd", d0_bcd, 16'h0000);
    check("rst_hex3", 16'(d0_h3), 16'h40);
    check("rst_lz_hex3", 16'(d1_h3), 16'h7F);
    check("rst_lz_hex0", 16'(d1_h0), 16'h40);
    rst_n = 1'b1;

    // single conversion from reset
    convert(1'b0, 2047);
    check("t1_bcd", d0_bcd, 16'h2047);
    check("t1_src", 16'(d0_src), 16'h0);
    check("t1_hex3", 16'(d0_h3), 16'h24);
    check("t1_hex2", 16'(d0_h2), 16'h40);
    check("t1_hex1", 16'(d0_h1), 16'h19);
    check("t1_hex0", 16'(d0_h0), 16'h78);

    // round robin with both held
    do_reset();
    val_a = 12; val_b = 999; req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(who);
      check("rr_who", 16'(who), 16'(i % 2));
      wait_done();
      if (i == 3) begin req_a = 1'b0; req_b = 1'b0; end
      check("rr_bcd", d0_bcd, (i % 2 == 1) ? 16'h0999 : 16'h0012);
      check("rr_src", 16'(d0_src), 16'(i % 2));
    end

    // maximum and zero
    convert(1'b1, 4095);
    check("max_bcd", d0_bcd, 16'h4095);
    check("max_hex3", 16'(d0_h3), 16'h19);
    check("max_hex1", 16'(d0_h1), 16'h18);
    check("max_hex0", 16'(d0_h0), 16'h12);
    convert(1'b1, 0);
    check("zero_bcd", d0_bcd, 16'h0000);

    // leading-zero blanking
    convert(1'b0, 7);
    check("lz7_hex3", 16'(d1_h3), 16'h7F);
    check("lz7_hex1", 16'(d1_h1), 16'h7F);
    check("lz7_hex0", 16'(d1_h0), 16'h78);
    convert(1'b0, 100);
    check("lz100_hex3", 16'(d1_h3), 16'h7F);
    check("lz100_hex2", 16'(d1_h2), 16'h79);
    check("lz100_hex1", 16'(d1_h1), 16'h40);
    check("lz100_hex0", 16'(d1_h0), 16'h40);

    // value change after grant is ignored; busy duration
    val_a = 1234; req_a = 1'b1;
    wait_ack(who);
    req_a = 1'b0;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 1) val_a = 567;
      if (!d0_busy) break;
      n++;
    end
    check("busy_cycles", 16'(n), 16'd13);
    check("hold_done", 16'(d0_done), 16'h1);
    check("hold_bcd", d0_bcd, 16'h1234);

    // reset mid-conversion
    convert(1'b0, 12);
    val_a = 2047; req_a = 1'b1;
    wait_ack(who);
    req_a = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_bcd", d0_bcd, 16'h0000);
    check("abort_busy", 16'(d0_busy), 16'h0);
    check("abort_ack", 16'(d0_ack_a), 16'h0);
    check("abort_done", 16'(d0_done), 16'h0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("abort_no_done", 16'(d0_done), 16'h0);
    end
    convert(1'b0, 2047);
    check("after_abort_bcd", d0_bcd, 16'h2047);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 249) != 0);
      req_a = ($urandom_range(0, 2) != 0);
      req_b = ($urandom_range(0, 2) != 0);
      val_a = W'($urandom_range(0, 4095));
      val_b = W'($urandom_range(0, 4095));
    end
    rst_n = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_bcd_sched.md
Name: display_bcd_sched

Overview:
- Shares the 4-digit seven-segment display between two 12-bit requesters, e.g. the serial adder result and an operand.
- Round-robin arbitration; the winning value is sampled once and converted to BCD sequentially (shift-add-3, one bit per clock).
- The four digits are committed atomically and drive HEX_3..HEX_0 (active-low) until the next conversion commits.
- Replaces a combinational subtract-compare converter with a small sequential datapath.

Parameters:
- WIDTH, 12, binary input width; supported range 4..13 (result must fit 4 BCD digits).
- BLANK_LZ, 0, 1 turns off leading-zero digits on HEX_3..HEX_1; HEX_0 is always lit.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_a  in  1  requester A wants the display; level, held until ack_a.
- val_a  in  WIDTH  requester A value; sampled only on its grant edge.
- req_b  in  1  requester B request.
- val_b  in  WIDTH  requester B value.
- ack_a  out  1  one-cycle pulse; A granted, val_a captured.
- ack_b  out  1  one-cycle pulse; B granted, val_b captured.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse; new digits committed.
- src  out  1  owner of displayed digits: 0=A, 1=B.
- bcd  out  16  committed digits {thousands, hundreds, tens, units}.
- HEX_0..HEX_3  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX_0 = units.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, ack_a=ack_b=done=busy=0, src=0, bcd=0, last_grant=B (A wins first tie), shift/count registers cleared.
- Reset display: BLANK_LZ=0 shows 0000; BLANK_LZ=1 shows only HEX_0="0".
- States: IDLE, SHIFT, COMMIT.
- IDLE, edge with req_a|req_b:
  - Grant A if only req_a; B if only req_b.
  - If both requests, grant the requester not equal to last_grant.
  - Load the binary shift register with the granted value and clear the 16-bit BCD work register.
  - cnt<=0; pulse the granted ack for one cycle; update last_grant and pending_src; go to SHIFT.
- SHIFT, each edge:
  - Add 3 to every BCD work nibble that is >=5.
  - Shift {work, binary} left by 1.
  - cnt++; after the WIDTH-th shift edge (cnt==WIDTH-1), go to COMMIT.
- COMMIT, one edge: bcd<=work; src<=pending_src; done<=1 for one cycle; go to IDLE.
- Latency: grant edge E0; WIDTH shift edges; commit at edge E0+WIDTH+1 (E13 for WIDTH=12). ack is visible in the cycle after E0; done and new HEX/bcd are visible in the cycle after E13.
- busy is high from the cycle after E0 up to and including the cycle where COMMIT is active. It is low in the cycle after commit; back-to-back grants are allowed on that IDLE edge.
- Requests arriving during SHIFT/COMMIT wait; nothing is queued beyond the level request.
- A requester that holds req after its ack is served again (round-robin still alternates if the other requester is requesting).
- val_x changes after the grant edge are ignored; displayed digits change only at COMMIT.
- Segment codes, active-low, hex of {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=18
  - blank=7F
  - nibbles >9 cannot occur; decode them as 7F.
- HEX outputs are combinational from the bcd register only, so they are glitch-free across conversion.
- Leading-zero blanking (BLANK_LZ=1):
  - HEX_3 blank if thousands==0.
  - HEX_2 blank if thousands==0 and hundreds==0.
  - HEX_1 blank if the upper three digits are all 0.
- Max 12-bit input: 4095 → bcd=16'h4095; no overflow.
- Reset mid-operation: abort the conversion; no done, no commit; all outputs return to reset values.

Test Plan:
- From reset, req_a=1, val_a=2047 → ack_a pulses the cycle after E0; done pulses the cycle after E13; bcd=16'h2047, src=0; HEX_3..0 = 24,40,19,78.
- req_a and req_b both high from reset, val_a=12, val_b=999 →
  - A served first (bcd=0012, src=0);
  - B granted on the next IDLE edge, bcd=0999, src=1;
  - with both held, grants alternate A,B,A.
- val_b=4095, then val_b=0 → bcd=4095 (HEX 19,40,18,12), then 0000.
- BLANK_LZ=1, val_a=7 → HEX_3..HEX_1=7F, HEX_0=78; val_a=100 → HEX_3=7F, HEX_2..0 = 79,40,40.
- Start 1234, change val_a to 567 two cycles after ack → committed bcd=1234; busy high for exactly 13 cycles.
- Start conversion of 2047 over a displayed 0012, pulse rst_n=0 at cycle 5 → no done; bcd=0, busy=0, ack=0 after the reset edge; the next request converts correctly.
